// File: rtl/gpo_cond_pkg.sv
// Shared types and config-word layout for the GPO line conditioner.
// The config word is {enable, polarity, delay, width}, MSB first.
package gpo_cond_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      ACTIVE = 2'd2
   } line_state_e;

   localparam int DEF_DELAY_W = 8;
   localparam int DEF_WIDTH_W = 8;
   localparam int CFG_W       = 2 + DEF_DELAY_W + DEF_WIDTH_W;

   // Field positions are derived from the widths so that a re-parameterised
   // channel stays consistent with the word the top receives.
   function automatic int cfg_width_lsb(input int dw, input int ww);
      cfg_width_lsb = 0 * (dw + ww);
   endfunction

   function automatic int cfg_delay_lsb(input int dw, input int ww);
      cfg_delay_lsb = ww + 0 * dw;
   endfunction

   function automatic int cfg_pol_bit(input int dw, input int ww);
      cfg_pol_bit = dw + ww;
   endfunction

   function automatic int cfg_en_bit(input int dw, input int ww);
      cfg_en_bit = dw + ww + 1;
   endfunction

   function automatic int max_int(input int a, input int b);
      max_int = (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/gpo_line_channel.sv
// One conditioned GPO line: config register, input synchroniser,
// delay/stretch FSM with its down-counter, and polarity-applied output.
module gpo_line_channel
   import gpo_cond_pkg::*;
#(
   parameter int DELAY_W = DEF_DELAY_W,
   parameter int WIDTH_W = DEF_WIDTH_W
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         in_line,
   input  logic                         cfg_we,
   input  logic [2+DELAY_W+WIDTH_W-1:0] cfg_data,
   output logic                         out_line,
   output logic                         busy
);

   localparam int CFG_BITS  = 2 + DELAY_W + WIDTH_W;
   localparam int CNT_W     = max_int(DELAY_W, WIDTH_W);
   localparam int WIDTH_LSB = cfg_width_lsb(DELAY_W, WIDTH_W);
   localparam int DELAY_LSB = cfg_delay_lsb(DELAY_W, WIDTH_W);
   localparam int POL_BIT   = cfg_pol_bit(DELAY_W, WIDTH_W);
   localparam int EN_BIT    = cfg_en_bit(DELAY_W, WIDTH_W);

   logic [CFG_BITS-1:0] cfg_q, cfg_d;
   logic                s1_q, s2_q, s3_q;
   line_state_e         state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                out_q, out_d;
   logic                busy_q, busy_d;

   logic               cfg_en;
   logic               cfg_pol;
   logic [DELAY_W-1:0] cfg_delay;
   logic [WIDTH_W-1:0] cfg_width;
   logic               rise;
   logic [CNT_W-1:0]   delay_load;
   logic [CNT_W-1:0]   width_load;

   assign cfg_en    = cfg_q[EN_BIT];
   assign cfg_pol   = cfg_q[POL_BIT];
   assign cfg_delay = cfg_q[DELAY_LSB +: DELAY_W];
   assign cfg_width = cfg_q[WIDTH_LSB +: WIDTH_W];
   assign rise      = s2_q & ~s3_q;

   // Loads are only used when the field is nonzero (delay) or clamped to
   // one cycle (width), so the counter can never wrap below zero.
   assign delay_load = CNT_W'(cfg_delay) - CNT_W'(1);
   assign width_load = (cfg_width == '0) ? '0 : (CNT_W'(cfg_width) - CNT_W'(1));

   always_comb begin
      cfg_d   = cfg_we ? cfg_data : cfg_q;
      state_d = state_q;
      cnt_d   = cnt_q;

      if (!cfg_en) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (rise) begin
                  if (cfg_delay == '0) begin
                     state_d = ACTIVE;
                     cnt_d   = width_load;
                  end else begin
                     state_d = DELAY;
                     cnt_d   = delay_load;
                  end
               end
            end
            DELAY: begin
               if (cnt_q == '0) begin
                  state_d = ACTIVE;
                  cnt_d   = width_load;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            ACTIVE: begin
               // Hold while the input is still high so long pulses pass through.
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end else if (!s2_q) begin
                  state_d = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      out_d  = (state_d == ACTIVE) ^ cfg_pol;
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cfg_q   <= '0;
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         s3_q    <= 1'b0;
         state_q <= IDLE;
         cnt_q   <= '0;
         out_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         cfg_q   <= cfg_d;
         s1_q    <= in_line;
         s2_q    <= s1_q;
         s3_q    <= s2_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         busy_q  <= busy_d;
      end
   end

   assign out_line = out_q;
   assign busy     = busy_q;

endmodule

// File: rtl/gpo_line_conditioner.sv
// Bank of per-line GPO pulse conditioners feeding the rfp_gpo pins.
// The top only decodes the config write address and concatenates ports.
module gpo_line_conditioner
   import gpo_cond_pkg::*;
#(
   parameter int NUM_LINES = 10,
   parameter int DELAY_W   = DEF_DELAY_W,
   parameter int WIDTH_W   = DEF_WIDTH_W,
   parameter int IDX_W     = 4
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic [NUM_LINES-1:0]         in_lines,
   input  logic                         cfg_we,
   input  logic [IDX_W-1:0]             cfg_line,
   input  logic [2+DELAY_W+WIDTH_W-1:0] cfg_data,
   output logic [NUM_LINES-1:0]         out_lines,
   output logic [NUM_LINES-1:0]         busy
);

   // Out-of-range indices match no channel, so those writes fall away.
   for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
      logic line_we;

      assign line_we = cfg_we && (cfg_line == IDX_W'(i));

      gpo_line_channel #(
         .DELAY_W (DELAY_W),
         .WIDTH_W (WIDTH_W)
      ) u_channel (
         .clk      (clk),
         .rstn     (rstn),
         .in_line  (in_lines[i]),
         .cfg_we   (line_we),
         .cfg_data (cfg_data),
         .out_line (out_lines[i]),
         .busy     (busy[i])
      );
   end

endmodule

// File: tb/tb_gpo_line_conditioner.sv
// Directed self-checking bench for gpo_line_conditioner.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_gpo_line_conditioner;

   logic        clk;
   logic        rstn;
   logic [9:0]  in_lines;
   logic        cfg_we;
   logic [3:0]  cfg_line;
   logic [17:0] cfg_data;
   logic [9:0]  out_lines;
   logic [9:0]  busy;

   int checkCount = 0;
   int passCount  = 0;
   int failCount  = 0;

   logic [9:0] expOut;
   logic [9:0] expBusy;

   gpo_line_conditioner dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_lines  (in_lines),
      .cfg_we    (cfg_we),
      .cfg_line  (cfg_line),
      .cfg_data  (cfg_data),
      .out_lines (out_lines),
      .busy      (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [9:0] observed, input logic [9:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [9:0] lines);
      in_lines = lines;
   endtask

   function automatic logic [17:0] mkCfg(input logic en, input logic pol,
                                         input logic [7:0] dly, input logic [7:0] wid);
      mkCfg = {en, pol, dly, wid};
   endfunction

   task automatic writeCfg(input logic [3:0] line, input logic [17:0] data);
      cfg_we   = 1'b1;
      cfg_line = line;
      cfg_data = data;
      tick(1);
      cfg_we   = 1'b0;
   endtask

   initial begin
      rstn     = 1'b0;
      in_lines = '0;
      cfg_we   = 1'b0;
      cfg_line = '0;
      cfg_data = '0;
      tick(2);
      checkOutput("reset_out", out_lines, 10'h000);
      checkOutput("reset_busy", busy, 10'h000);
      rstn = 1'b1;

      // Unconfigured lines ignore activity.
      applyStimulus(10'h3FF);
      for (int c = 0; c < 6; c++) begin
         tick(1);
         if (c == 2) applyStimulus(10'h000);
         checkOutput("unconf_out", out_lines, 10'h000);
         checkOutput("unconf_busy", busy, 10'h000);
      end
      tick(2);

      // Line 0: zero delay, zero width -> one-cycle pulse at k+2.
      writeCfg(4'd0, mkCfg(1'b1, 1'b0, 8'd0, 8'd0));
      applyStimulus(10'h001);
      tick(1);
      applyStimulus(10'h000);
      checkOutput("l0_k_out", out_lines, 10'h000);
      tick(1);
      checkOutput("l0_k1_out", out_lines, 10'h000);
      checkOutput("l0_k1_busy", busy, 10'h000);
      tick(1);
      checkOutput("l0_k2_out", out_lines, 10'h001);
      checkOutput("l0_k2_busy", busy, 10'h001);
      tick(1);
      checkOutput("l0_k3_out", out_lines, 10'h000);
      checkOutput("l0_k3_busy", busy, 10'h000);
      tick(2);

      // Line 3: delay 5, width 10, with a retrigger inside the pulse window.
      writeCfg(4'd3, mkCfg(1'b1, 1'b0, 8'd5, 8'd10));
      applyStimulus(10'h008);
      tick(2);
      applyStimulus(10'h000);
      checkOutput("l3_k1_out", out_lines, 10'h000);
      checkOutput("l3_k1_busy", busy, 10'h000);
      for (int c = 2; c <= 20; c++) begin
         tick(1);
         if (c == 8) applyStimulus(10'h008);
         if (c == 9) applyStimulus(10'h000);
         expOut  = (c >= 7 && c <= 16) ? 10'h008 : 10'h000;
         expBusy = (c >= 2 && c <= 16) ? 10'h008 : 10'h000;
         checkOutput("l3_out", out_lines, expOut);
         checkOutput("l3_busy", busy, expBusy);
      end

      // Line 9: width 4, input held 20 cycles -> output follows input length.
      writeCfg(4'd9, mkCfg(1'b1, 1'b0, 8'd0, 8'd4));
      applyStimulus(10'h200);
      for (int c = 0; c <= 23; c++) begin
         tick(1);
         if (c == 19) applyStimulus(10'h000);
         expOut  = (c >= 2 && c <= 21) ? 10'h200 : 10'h000;
         checkOutput("l9_long_out", out_lines, expOut);
         checkOutput("l9_long_busy", busy, expOut);
      end

      // Line 9 polarity inverted: idles high one edge after the write lands.
      writeCfg(4'd9, mkCfg(1'b1, 1'b1, 8'd0, 8'd4));
      checkOutput("l9_pol_land", out_lines, 10'h000);
      tick(1);
      checkOutput("l9_pol_idle", out_lines, 10'h200);
      checkOutput("l9_pol_idle_busy", busy, 10'h000);
      applyStimulus(10'h200);
      tick(1);
      applyStimulus(10'h000);
      for (int c = 1; c <= 7; c++) begin
         tick(1);
         expOut  = (c >= 2 && c <= 5) ? 10'h000 : 10'h200;
         expBusy = (c >= 2 && c <= 5) ? 10'h200 : 10'h000;
         checkOutput("l9_pol_out", out_lines, expOut);
         checkOutput("l9_pol_busy", busy, expBusy);
      end

      // Out-of-range write must not enable any line.
      writeCfg(4'd12, mkCfg(1'b1, 1'b0, 8'd0, 8'd0));
      applyStimulus(10'h1F6);
      for (int c = 0; c < 6; c++) begin
         tick(1);
         if (c == 1) applyStimulus(10'h000);
         checkOutput("oor_out", out_lines, 10'h200);
         checkOutput("oor_busy", busy, 10'h000);
      end

      // Disable line 3 while ACTIVE.
      applyStimulus(10'h008);
      tick(1);
      applyStimulus(10'h000);
      tick(7);
      checkOutput("dis_active_out", out_lines, 10'h208);
      checkOutput("dis_active_busy", busy, 10'h008);
      tick(1);
      writeCfg(4'd3, mkCfg(1'b0, 1'b0, 8'd5, 8'd10));
      checkOutput("dis_land_out", out_lines, 10'h208);
      checkOutput("dis_land_busy", busy, 10'h008);
      tick(1);
      checkOutput("dis_next_out", out_lines, 10'h200);
      checkOutput("dis_next_busy", busy, 10'h000);

      // Async reset during a DELAY on line 5.
      writeCfg(4'd5, mkCfg(1'b1, 1'b0, 8'd20, 8'd3));
      applyStimulus(10'h020);
      tick(1);
      applyStimulus(10'h000);
      tick(3);
      checkOutput("l5_delay_busy", busy, 10'h020);
      checkOutput("l5_delay_out", out_lines, 10'h200);
      #2;
      rstn = 1'b0;
      #1;
      checkOutput("async_rst_out", out_lines, 10'h000);
      checkOutput("async_rst_busy", busy, 10'h000);
      tick(1);
      rstn = 1'b1;
      applyStimulus(10'h3FF);
      for (int c = 0; c < 6; c++) begin
         tick(1);
         if (c == 1) applyStimulus(10'h000);
         checkOutput("post_rst_out", out_lines, 10'h000);
         checkOutput("post_rst_busy", busy, 10'h000);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
